// File: rtl/uart_pkg.sv
// uart_pkg: constants and receive FSM state shared by the UART transmit and receive sides
package uart_pkg;
  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input, resets to the idle-high level
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] ff_q;
  always_ff @(posedge clk_i) ff_q <= rst_i ? 2'b11 : {ff_q[0], d_i};
  assign q_o = ff_q[1];
endmodule

// File: rtl/uart_rcv_control.sv
// uart_rcv_control: oversampled UART receive FSM driving the shift register and status flags
module uart_rcv_control
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic Clock,
  input  logic Reset,
  input  logic BaudTick,
  input  logic RxD,
  input  logic Read,
  output logic Shift,
  output logic RxBit,
  output logic Busy,
  output logic DataReady,
  output logic FramingError,
  output logic Overrun
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
  rx_state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic shift_q, shift_d, rxbit_q, rxbit_d;
  logic dr_q, dr_d, fe_q, fe_d, ov_q, ov_d;
  logic rx_s, stop_smp, stop_ok;
  sync_2ff u_sync (
    .clk_i(Clock),
    .rst_i(Reset),
    .d_i  (RxD),
    .q_o  (rx_s)
  );
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = 1'b0;
    rxbit_d  = rxbit_q;
    stop_smp = 1'b0;
    if (BaudTick) begin
      case (state_q)
        RX_IDLE: if (!rx_s) begin
          state_d = RX_START;
          tick_d  = '0;
        end
        RX_START: if (tick_q == HALF) begin
          state_d = rx_s ? RX_IDLE : RX_DATA;
          tick_d  = '0;
          bit_d   = '0;
        end else tick_d = tick_q + 1'b1;
        RX_DATA: if (tick_q == LAST) begin
          shift_d = 1'b1;
          rxbit_d = rx_s;
          tick_d  = '0;
          bit_d   = bit_q + 1'b1;
          state_d = (bit_q == BLAST) ? RX_STOP : RX_DATA;
        end else tick_d = tick_q + 1'b1;
        RX_STOP: if (tick_q == LAST) begin
          stop_smp = 1'b1;
          state_d  = RX_IDLE;
          tick_d   = '0;
        end else tick_d = tick_q + 1'b1;
        default: state_d = RX_IDLE;
      endcase
    end
  end
  // a flag being set in the same cycle as a Read wins over the clear
  assign stop_ok = stop_smp & rx_s;
  assign dr_d    = stop_ok | (dr_q & ~Read);
  assign fe_d    = (stop_smp & ~rx_s) | (fe_q & ~Read);
  assign ov_d    = (stop_ok & dr_q & ~Read) | (ov_q & ~Read);
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= RX_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= 1'b0;
      rxbit_q <= 1'b1;
      dr_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      rxbit_q <= rxbit_d;
      dr_q    <= dr_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end
  assign Shift        = shift_q;
  assign RxBit        = rxbit_q;
  assign Busy         = (state_q != RX_IDLE);
  assign DataReady    = dr_q;
  assign FramingError = fe_q;
  assign Overrun      = ov_q;
endmodule

// File: tb/tb_uart_rcv_control.sv
// tb_uart_rcv_control: directed frames checked against an elapsed-tick behavioural model
module tb_uart_rcv_control;
  localparam int OS = 16;
  localparam int DB = 8;
  logic clk = 1'b0;
  logic Reset = 1'b1, BaudTick = 1'b0, RxD = 1'b1, Read = 1'b0;
  logic Shift, RxBit, Busy, DataReady, FramingError, Overrun;
  int checks = 0, errors = 0;
  int tcnt = 0;
  bit tick_en = 1'b1;
  uart_rcv_control #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .Clock(clk), .Reset(Reset), .BaudTick(BaudTick), .RxD(RxD), .Read(Read),
    .Shift(Shift), .RxBit(RxBit), .Busy(Busy), .DataReady(DataReady),
    .FramingError(FramingError), .Overrun(Overrun)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    BaudTick = tick_en && (tcnt % 4 == 3);
    tcnt++;
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask
  // model: time since start detection in ticks decides every event
  logic ms1 = 1'b1, ms2 = 1'b1, line;
  bit m_busy = 1'b0, m_shift = 1'b0, m_bit = 1'b1, m_dr = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  bit sdone, sok;
  int m_el = 0, k;
  always @(posedge clk) begin
    if (Reset) begin
      ms1 = 1'b1; ms2 = 1'b1; m_busy = 1'b0; m_el = 0; m_shift = 1'b0;
      m_bit = 1'b1; m_dr = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      line = ms2; ms2 = ms1; ms1 = RxD;
      m_shift = 1'b0; sdone = 1'b0; sok = 1'b0;
      if (BaudTick) begin
        if (m_busy) begin
          m_el++;
          if (m_el == OS / 2 && line) m_busy = 1'b0;
          else if (m_el > OS / 2 && (m_el - OS / 2) % OS == 0) begin
            k = (m_el - OS / 2) / OS;
            if (k <= DB) begin m_shift = 1'b1; m_bit = line; end
            else begin sdone = 1'b1; sok = line; m_busy = 1'b0; end
          end
        end else if (!line) begin
          m_busy = 1'b1; m_el = 0;
        end
      end
      m_ov = (sdone && sok && m_dr && !Read) ? 1'b1 : (Read ? 1'b0 : m_ov);
      m_dr = (sdone && sok) ? 1'b1 : (Read ? 1'b0 : m_dr);
      m_fe = (sdone && !sok) ? 1'b1 : (Read ? 1'b0 : m_fe);
    end
  end
  always @(negedge clk) begin
    chk("Shift", 32'(Shift), 32'(m_shift));
    chk("RxBit", 32'(RxBit), 32'(m_bit));
    chk("Busy", 32'(Busy), 32'(m_busy));
    chk("DataReady", 32'(DataReady), 32'(m_dr));
    chk("FramingError", 32'(FramingError), 32'(m_fe));
    chk("Overrun", 32'(Overrun), 32'(m_ov));
  end
  // downstream right-shift register plus capture log
  logic [7:0] sr = '0, seq = '0;
  int nsh = 0;
  time sh_t[16];
  bit saw_busy = 1'b0;
  always @(posedge clk) if (Shift) begin
    sr = {RxBit, sr[7:1]};
    seq = {seq[6:0], RxBit};
    if (nsh < 16) sh_t[nsh] = $time;
    nsh++;
  end
  always @(negedge clk) if (Busy) saw_busy = 1'b1;
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_read();
    @(negedge clk); Read = 1'b1;
    @(negedge clk); Read = 1'b0;
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input bit rd_at_stop, input int rst_bit);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int b = 0; b < 10; b++)
      for (int c = 0; c < 64; c++) begin
        @(negedge clk);
        RxD = fr[b];
        Read = rd_at_stop && b == 9 && BaudTick && m_busy && m_el == 151;
        if (rst_bit >= 0 && b == rst_bit + 1 && c == 32) begin
          Reset = 1'b1;
          @(negedge clk);
          Reset = 1'b0; RxD = 1'b1; nsh = 0;
          return;
        end
      end
    @(negedge clk);
    Read = 1'b0; RxD = 1'b1;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rxbit", 32'(RxBit), 1); chk("rst_busy", 32'(Busy), 0);
    Reset = 1'b0;
    nsh = 0;
    idle(1200);
    chk("idle_nshift", nsh, 0); chk("idle_busy", 32'(Busy), 0);
    chk("idle_rxbit", 32'(RxBit), 1); chk("idle_dr", 32'(DataReady), 0);
    nsh = 0; seq = '0;
    send(8'hA5, 1'b1, 1'b0, -1); idle(80);
    chk("a5_nshift", nsh, 8); chk("a5_data", 32'(sr), 32'h A5);
    chk("a5_bitseq", 32'(seq), 32'b10100101);
    chk("a5_dr", 32'(DataReady), 1); chk("a5_fe", 32'(FramingError), 0);
    for (int i = 1; i < 8; i++) chk("a5_spacing", 32'(sh_t[i] - sh_t[i-1]), 640);
    pulse_read();
    chk("a5_read_dr", 32'(DataReady), 0);
    nsh = 0; saw_busy = 1'b0;
    RxD = 1'b0; idle(20); RxD = 1'b1; idle(80);
    chk("glitch_nshift", nsh, 0); chk("glitch_sawbusy", 32'(saw_busy), 1);
    chk("glitch_busy", 32'(Busy), 0); chk("glitch_dr", 32'(DataReady), 0);
    send(8'h3C, 1'b0, 1'b0, -1); idle(80);
    chk("fe_set", 32'(FramingError), 1); chk("fe_dr", 32'(DataReady), 0);
    pulse_read();
    chk("fe_clear", 32'(FramingError), 0);
    send(8'h11, 1'b1, 1'b0, -1); send(8'h22, 1'b1, 1'b0, -1); idle(80);
    chk("ov_set", 32'(Overrun), 1); chk("ov_dr", 32'(DataReady), 1);
    chk("ov_data", 32'(sr), 32'h22);
    pulse_read();
    chk("ov_clear", 32'(Overrun), 0);
    send(8'h11, 1'b1, 1'b0, -1); send(8'h22, 1'b1, 1'b1, -1); idle(80);
    chk("ovrd_dr", 32'(DataReady), 1); chk("ovrd_ov", 32'(Overrun), 0);
    pulse_read();
    send(8'h81, 1'b1, 1'b0, -1); idle(80);
    tick_en = 1'b0; idle(8);
    pulse_read(); idle(4);
    chk("notick_dr", 32'(DataReady), 0); chk("notick_busy", 32'(Busy), 0);
    tick_en = 1'b1;
    send(8'h81, 1'b1, 1'b0, -1); idle(80);
    chk("pre_rst_dr", 32'(DataReady), 1);
    send(8'hC3, 1'b1, 1'b0, 3);
    chk("rst_mid_busy", 32'(Busy), 0); chk("rst_mid_dr", 32'(DataReady), 0);
    chk("rst_mid_rxbit", 32'(RxBit), 1);
    idle(200);
    chk("rst_mid_nshift", nsh, 0);
    send(8'h5A, 1'b1, 1'b0, -1); idle(80);
    chk("post_rst_nshift", nsh, 8); chk("post_rst_data", 32'(sr), 32'h5A);
    chk("post_rst_dr", 32'(DataReady), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
